commit_trace_checker: RTL
=========================

// Module: commit_trace_checker
// PURPOSE
//  Hardware checker for the processor's committed-event stream: it consumes the same commit signals the
//  simulation trace monitor writes out (REG / LOAD / STORE / HALT) and compares them in order against an
//  expected-event stream. It sits beside proc_hier, is fed by probes of the writeback/memory stage and by
//  a golden-trace source, and reports pass/fail with the index of the first divergent event.
// PARAMETERS
//  DEPTH    16    observed-event FIFO entries; power of 2, >= 8
//  TIMEOUT  1024  cycles FIFO may be non-empty with no expected-event handshake before failing
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous active-high reset
//  RegWrite       in   1   register file written this cycle
//  WriteRegister  in   3   register written
//  WriteData      in   16  register write data
//  MemRead        in   1   data memory read this cycle
//  MemWrite       in   1   data memory write this cycle
//  MemAddress     in   16  data memory address
//  MemDataIn      in   16  store data
//  MemDataOut     in   16  load data
//  Halt           in   1   halt committed
//  exp_valid      in   1   expected event available
//  exp_ready      out  1   checker accepts expected event
//  exp_kind       in   2   0=REG 1=LOAD 2=STORE 3=HALT
//  exp_a          in   16  REG: {13'b0,reg}; LOAD/STORE: address; HALT: don't care
//  exp_b          in   16  REG: write data; LOAD: load data; STORE: store data; HALT: don't care
//  done           out  1   checking finished (PASS or FAIL)
//  pass           out  1   HALT matched with no prior error
//  err_code       out  2   0=none 1=mismatch 2=FIFO overflow 3=timeout
//  err_index      out  16  count of events matched before the failure
//  event_count    out  16  events matched so far (wraps at 2^16)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state RUN, FIFO empty, halt_seen=0, timeout counter 0; done=0 pass=0
//    err_code=0 err_index=0 event_count=0. Inputs are ignored while rst=1. Reset is honoured in any state.
//  - Capture (RUN, halt_seen=0): each cycle, events are built in fixed order REG (if RegWrite), LOAD (if
//    MemRead), STORE (if MemWrite), HALT (if Halt); 0..4 entries pushed. Both MemRead and MemWrite high
//    -> both pushed. HALT pushed -> halt_seen=1; all later commit inputs are ignored.
//  - Entry = {kind[1:0], a[15:0], b[15:0]}; encoding identical to exp_* fields, unused bits zero.
//  - Overflow: if occupancy (before this cycle's pop) + pushes > DEPTH -> nothing pushed, FAIL, err_code=2.
//  - Entries pushed in cycle N are visible at the head from cycle N+1 (no bypass).
//  - exp_ready = (state==RUN) && FIFO non-empty. Handshake when exp_valid && exp_ready: head compared to
//    {exp_kind,exp_a,exp_b} combinationally (a/b ignored for HALT); head popped regardless of result.
//  - Match: event_count+1. Matched HALT -> PASS next cycle. Mismatch -> FAIL next cycle, err_code=1,
//    err_index=event_count at time of compare. Push and pop in the same cycle are allowed.
//  - Timeout counter: cleared on handshake or when FIFO empty; else increments; reaching TIMEOUT -> FAIL,
//    err_code=3, err_index=event_count.
//  - Error precedence in one cycle: mismatch > overflow > timeout.
//  - PASS: done=1 pass=1. FAIL: done=1 pass=0. Both terminal until rst: exp_ready=0, inputs ignored,
//    all outputs held.
//  - FIFO pointers log2(DEPTH) bits + 1 wrap bit; full/empty from pointer compare.
// TESTING
//  - REG r3=0x1234 then HALT; expected REG{3,0x1234}, HALT -> pass=1 done=1 event_count=2 err_code=0.
//  - One cycle RegWrite r1=0x00AA + MemWrite addr 0x0040 data 0x5555 -> FIFO holds REG then STORE;
//    matching expected stream accepted in that order, event_count=2.
//  - Expected LOAD{0x0010,0xBEEF}, observed LOAD data 0xBEEE as 3rd event -> err_code=1 err_index=2 pass=0.
//  - DEPTH=8, exp_valid=0, commit 3 events/cycle for 3 cycles -> 3rd cycle overflows: err_code=2,
//    FIFO count stays 6.
//  - TIMEOUT=16, one REG pushed, exp_valid=0 -> FAIL with err_code=3 exactly 16 cycles after push visible.
//  - rst asserted mid-run with 5 entries queued -> next cycle FIFO empty, exp_ready=0, all outputs zero;
//    new stream checks normally.

Source files
------------

// File: rtl/commit_trace_checker.sv
// commit_trace_checker: compares the in-order stream of committed processor
// events (REG / LOAD / STORE / HALT) against an expected-event stream and
// reports pass/fail with the index of the first divergent event.
module commit_trace_checker #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite,
    input  logic [2:0]  WriteRegister,
    input  logic [15:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] MemAddress,
    input  logic [15:0] MemDataIn,
    input  logic [15:0] MemDataOut,
    input  logic        Halt,
    input  logic        exp_valid,
    output logic        exp_ready,
    input  logic [1:0]  exp_kind,
    input  logic [15:0] exp_a,
    input  logic [15:0] exp_b,
    output logic        done,
    output logic        pass,
    output logic [1:0]  err_code,
    output logic [15:0] err_index,
    output logic [15:0] event_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = 34;

    localparam logic [1:0] K_REG   = 2'd0;
    localparam logic [1:0] K_LOAD  = 2'd1;
    localparam logic [1:0] K_STORE = 2'd2;
    localparam logic [1:0] K_HALT  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_e;

    // HALT carries no payload, so only its kind is compared
    function automatic logic ev_match(input logic [EW-1:0] head,
                                      input logic [1:0] kind,
                                      input logic [15:0] a,
                                      input logic [15:0] b);
        logic m;
        if (head[33:32] != kind) begin
            m = 1'b0;
        end else if (kind == K_HALT) begin
            m = 1'b1;
        end else begin
            m = (head[31:16] == a) && (head[15:0] == b);
        end
        return m;
    endfunction

    state_e         state_q, state_d;
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic           halt_seen_q, halt_seen_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;
    logic [1:0]     err_code_q, err_code_d;
    logic [15:0]    err_index_q, err_index_d;
    logic [15:0]    event_count_q, event_count_d;
    logic [EW-1:0]  mem_q [DEPTH];

    logic [EW-1:0]  ent_s [4];
    logic [AW-1:0]  wr_idx_s [4];
    logic [2:0]     pos_ld_s, pos_st_s, pos_ht_s, push_n_s;
    logic           push_en_s;
    logic           empty_s, hs_s, match_s, overflow_s;
    logic [AW:0]    count_s;
    logic [AW+1:0]  occ_sum_s;
    logic [EW-1:0]  head_s;

    assign empty_s     = (wr_ptr_q == rd_ptr_q);
    assign count_s     = wr_ptr_q - rd_ptr_q;
    assign head_s      = mem_q[rd_ptr_q[AW-1:0]];
    assign exp_ready   = (state_q == ST_RUN) && !empty_s;
    assign hs_s        = exp_valid && exp_ready;
    assign match_s     = ev_match(head_s, exp_kind, exp_a, exp_b);
    assign occ_sum_s   = {1'b0, count_s} + (AW+2)'(push_n_s);
    assign overflow_s  = occ_sum_s > (AW+2)'(DEPTH);

    assign done        = done_q;
    assign pass        = pass_q;
    assign err_code    = err_code_q;
    assign err_index   = err_index_q;
    assign event_count = event_count_q;

    // Pack this cycle's commits into slots 0..3 in REG, LOAD, STORE, HALT order
    always_comb begin
        pos_ld_s = {2'b00, RegWrite};
        pos_st_s = pos_ld_s + {2'b00, MemRead};
        pos_ht_s = pos_st_s + {2'b00, MemWrite};
        if (halt_seen_q) begin
            push_n_s = 3'd0;
        end else begin
            push_n_s = pos_ht_s + {2'b00, Halt};
        end
        for (int k = 0; k < 4; k++) begin
            wr_idx_s[k] = wr_ptr_q[AW-1:0] + AW'(k);
            if (RegWrite && (k == 0)) begin
                ent_s[k] = {K_REG, 13'd0, WriteRegister, WriteData};
            end else if (MemRead && (pos_ld_s == 3'(k))) begin
                ent_s[k] = {K_LOAD, MemAddress, MemDataOut};
            end else if (MemWrite && (pos_st_s == 3'(k))) begin
                ent_s[k] = {K_STORE, MemAddress, MemDataIn};
            end else if (Halt && (pos_ht_s == 3'(k))) begin
                ent_s[k] = {K_HALT, 16'd0, 16'd0};
            end else begin
                ent_s[k] = {EW{1'b0}};
            end
        end
    end

    // Next-state: pop/compare on handshake, push commits, track timeout, pick verdict
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        halt_seen_d   = halt_seen_q;
        tmo_d         = tmo_q;
        done_d        = done_q;
        pass_d        = pass_q;
        err_code_d    = err_code_q;
        err_index_d   = err_index_q;
        event_count_d = event_count_q;
        push_en_s     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hs_s) begin
                    rd_ptr_d = rd_ptr_q + (AW+1)'(1);
                    if (match_s) begin
                        event_count_d = event_count_q + 16'd1;
                    end else begin
                        event_count_d = event_count_q;
                    end
                end else begin
                    rd_ptr_d = rd_ptr_q;
                end
                if (hs_s || empty_s) begin
                    tmo_d = {TW{1'b0}};
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
                // Mismatch outranks overflow, which outranks timeout
                if (hs_s && !match_s) begin
                    state_d     = ST_FAIL;
                    done_d      = 1'b1;
                    err_code_d  = 2'd1;
                    err_index_d = event_count_q;
                end else if (overflow_s) begin
                    state_d     = ST_FAIL;
                    done_d      = 1'b1;
                    err_code_d  = 2'd2;
                    err_index_d = event_count_d;
                end else begin
                    push_en_s   = 1'b1;
                    wr_ptr_d    = wr_ptr_q + (AW+1)'(push_n_s);
                    halt_seen_d = halt_seen_q | Halt;
                    if (hs_s && (head_s[33:32] == K_HALT)) begin
                        state_d = ST_PASS;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else if (tmo_d == TW'(TIMEOUT)) begin
                        state_d     = ST_FAIL;
                        done_d      = 1'b1;
                        err_code_d  = 2'd3;
                        err_index_d = event_count_q;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_PASS, ST_FAIL: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_FAIL;
                done_d  = 1'b1;
                pass_d  = 1'b0;
            end
        endcase
    end

    // State and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            halt_seen_q   <= 1'b0;
            tmo_q         <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_code_q    <= 2'd0;
            err_index_q   <= 16'd0;
            event_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            halt_seen_q   <= halt_seen_d;
            tmo_q         <= tmo_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            err_code_q    <= err_code_d;
            err_index_q   <= err_index_d;
            event_count_q <= event_count_d;
        end
    end

    // FIFO storage: write up to four packed entries starting at the write pointer
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst && push_en_s && (3'(k) < push_n_s)) begin
                mem_q[wr_idx_s[k]] <= ent_s[k];
            end
        end
    end

endmodule
